// File: rtl/higher_lower_round_ctrl.sv
// Round sequencer for the higher/lower game core.
// Debounces the two raw guess buttons, issues one-cycle guess pulses to the
// core, counts each round's win/lose result, and tracks score, lives and
// game-over. Core value codes: 0-9 digit, 10 = win, 11 = lose.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a valid guess press
// ISSUE | guess pulse high for this single cycle
// WAIT  | watching for a 10/11 result code, bounded by RESULT_TIMEOUT
// HOLD  | result counted; waiting for core digit and buttons released
// OVER  | no lives left; any valid press restarts without a guess pulse
module higher_lower_round_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int LIVES           = 3,
  parameter int SCORE_MAX       = 9,
  parameter int RESULT_TIMEOUT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_higher_raw,
  input  logic       btn_lower_raw,
  input  logic [3:0] game_value,
  output logic       game_btn_higher,
  output logic       game_btn_lower,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic [3:0] disp_digit
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W = (RESULT_TIMEOUT < 2) ? 1 : $clog2(RESULT_TIMEOUT + 1);

  // The load value already accounts for the first stable cycle, so the
  // level is accepted when the counter reaches 1.
  localparam logic [DB_W-1:0] DB_LOAD     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE      = DB_W'(1);
  localparam logic [TO_W-1:0] TO_LOAD     = TO_W'(RESULT_TIMEOUT - 1);
  localparam logic [3:0]      SCORE_MAX_V = 4'(SCORE_MAX);
  localparam logic [1:0]      LIVES_INIT  = 2'(LIVES);
  localparam logic [3:0]      CODE_WIN    = 4'd10;
  localparam logic [3:0]      CODE_LOSE   = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_OVER
  } state_t;

  // Index 0 = higher button, index 1 = lower button.
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      lvl_prev_q;
  logic [1:0]      deb_q;
  logic [1:0]      deb_prev_q;
  logic [DB_W-1:0] db_cnt_q [2];

  state_t          state_q;
  logic [TO_W-1:0] tmo_q;
  logic            pulse_h_q;
  logic            pulse_l_q;
  logic [3:0]      score_q;
  logic [1:0]      lives_q;
  logic            over_q;
  logic [3:0]      disp_q;

  logic [1:0] press;
  logic       valid_h;
  logic       valid_l;
  logic       any_valid;

  // Synchronise both buttons and accept a level once it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_prev_q <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= {btn_lower_raw, btn_higher_raw};
      sync2_q    <= sync1_q;
      lvl_prev_q <= sync2_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != lvl_prev_q[i]) begin
          db_cnt_q[i] <= DB_LOAD;
        end else if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] <= DB_ONE) begin
            deb_q[i]    <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] - DB_ONE;
          end
        end
      end
    end
  end

  // A press is a debounced rising edge; simultaneous or overlapping presses are ambiguous and dropped.
  always_comb begin
    press     = deb_q & ~deb_prev_q;
    valid_h   = press[0] & ~press[1] & ~deb_q[1];
    valid_l   = press[1] & ~press[0] & ~deb_q[0];
    any_valid = valid_h | valid_l;
  end

  // Round sequencer with registered pulses, score, lives, game-over and display digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tmo_q     <= '0;
      pulse_h_q <= 1'b0;
      pulse_l_q <= 1'b0;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      over_q    <= 1'b0;
      disp_q    <= '0;
    end else begin
      disp_q    <= (state_q == S_OVER) ? score_q : game_value;
      pulse_h_q <= 1'b0;
      pulse_l_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            pulse_h_q <= valid_h;
            pulse_l_q <= valid_l;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_q   <= TO_LOAD;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (game_value == CODE_WIN) begin
            if (score_q < SCORE_MAX_V) score_q <= score_q + 4'd1;
            state_q <= S_HOLD;
          end else if (game_value == CODE_LOSE) begin
            if (lives_q != 2'd0) lives_q <= lives_q - 2'd1;
            state_q <= S_HOLD;
          end else if (tmo_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q - TO_W'(1);
          end
        end
        S_HOLD: begin
          // Leaving only after the core returns to a digit keeps one result per round.
          if ((game_value < CODE_WIN) && (deb_q == 2'b00)) begin
            if (lives_q == 2'd0) begin
              over_q  <= 1'b1;
              state_q <= S_OVER;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_OVER: begin
          if (any_valid) begin
            score_q <= '0;
            lives_q <= LIVES_INIT;
            over_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign game_btn_higher = pulse_h_q;
  assign game_btn_lower  = pulse_l_q;
  assign score           = score_q;
  assign lives           = lives_q;
  assign game_over       = over_q;
  assign disp_digit      = disp_q;

endmodule

// File: tb/tb_higher_lower_round_ctrl.sv
// Bench for higher_lower_round_ctrl with a small game-core model that answers
// each guess pulse with a result code held for 20 cycles.
module tb_higher_lower_round_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_higher_raw = 1'b0;
  logic       btn_lower_raw = 1'b0;
  logic [3:0] game_value = 4'd5;
  logic       game_btn_higher;
  logic       game_btn_lower;
  logic [3:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic [3:0] disp_digit;

  int n_vec = 0;
  int n_err = 0;
  int cnt_h = 0;
  int cnt_l = 0;
  logic prev_h = 1'b0;
  logic prev_l = 1'b0;

  logic [3:0] resp_code = 4'd0;
  int         hold_cnt = 0;
  localparam logic [3:0] BASE_VALUE = 4'd5;

  higher_lower_round_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .LIVES(3),
    .SCORE_MAX(9),
    .RESULT_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_higher_raw(btn_higher_raw),
    .btn_lower_raw(btn_lower_raw),
    .game_value(game_value),
    .game_btn_higher(game_btn_higher),
    .game_btn_lower(game_btn_lower),
    .score(score),
    .lives(lives),
    .game_over(game_over),
    .disp_digit(disp_digit)
  );

  always #5 clk = ~clk;

  // Core model: latency 1, result code shown for 20 cycles, then back to the digit.
  always @(posedge clk) begin
    if ((game_btn_higher || game_btn_lower) && resp_code >= 4'd10) begin
      game_value <= resp_code;
      hold_cnt   <= 20;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) game_value <= BASE_VALUE;
    end
  end

  // Pulse monitor: counts pulses, flags overlap and pulses wider than one cycle.
  always @(negedge clk) begin
    if (game_btn_higher) cnt_h++;
    if (game_btn_lower) cnt_l++;
    if (game_btn_higher && game_btn_lower) begin
      n_err++;
      $display("FAIL pulse_overlap: both guess pulses high at %0t, required at most one", $time);
    end
    if ((game_btn_higher && prev_h) || (game_btn_lower && prev_l)) begin
      n_err++;
      $display("FAIL pulse_width: pulse high two cycles in a row at %0t, required 1 cycle", $time);
    end
    prev_h = game_btn_higher;
    prev_l = game_btn_lower;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_counts(input string nm, input int s, input int l, input int o);
    chk({nm, "_score"}, int'(score), s);
    chk({nm, "_lives"}, int'(lives), l);
    chk({nm, "_over"}, int'(game_over), o);
  endtask

  typedef struct {
    logic       hi;
    logic [3:0] code;
    int         exp_p;
    int         exp_score;
    int         exp_lives;
    int         exp_over;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int h0, l0, pulse_at, chosen, other, exp_disp;
    logic saw, found;

    tbl[0] = '{1'b1, 4'd10, 1, 1, 3, 0};   // win
    tbl[1] = '{1'b0, 4'd10, 1, 2, 3, 0};   // win via lower
    tbl[2] = '{1'b1, 4'd11, 1, 2, 2, 0};   // lose
    tbl[3] = '{1'b1, 4'd0,  1, 2, 2, 0};   // core never answers
    tbl[4] = '{1'b0, 4'd11, 1, 2, 1, 0};   // lose
    tbl[5] = '{1'b1, 4'd11, 1, 2, 0, 1};   // last life -> OVER
    tbl[6] = '{1'b1, 4'd10, 0, 0, 3, 0};   // restart press, no pulse
    for (int i = 7; i < 19; i++)
      tbl[i] = '{(i % 2 == 0), 4'd10, 1, ((i - 6) > 9) ? 9 : (i - 6), 3, 0};

    // Reset values.
    repeat (3) @(negedge clk);
    chk("reset_pulse_h", int'(game_btn_higher), 0);
    chk("reset_pulse_l", int'(game_btn_lower), 0);
    chk_counts("reset", 0, 3, 0);
    chk("reset_disp", int'(disp_digit), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Bouncy higher button, then a stable press.
    resp_code = 4'd10;
    h0 = cnt_h; l0 = cnt_l; pulse_at = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c < 20 && c % 2 == 0) btn_higher_raw = ~btn_higher_raw;
      if (c == 20) btn_higher_raw = 1'b1;
      if (c == 30) btn_higher_raw = 1'b0;
      if (game_btn_higher && pulse_at < 0) pulse_at = c;
    end
    chk("bounce_pulses_h", cnt_h - h0, 1);
    chk("bounce_pulses_l", cnt_l - l0, 0);
    chk("bounce_latency_ok", int'(pulse_at >= 24), 1);
    chk_counts("bounce", 1, 3, 0);

    // Both buttons in the same cycle.
    h0 = cnt_h; l0 = cnt_l;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin btn_higher_raw = 1'b1; btn_lower_raw = 1'b1; end
      if (c == 15) begin btn_higher_raw = 1'b0; btn_lower_raw = 1'b0; end
    end
    chk("both_pulses", (cnt_h - h0) + (cnt_l - l0), 0);
    chk_counts("both", 1, 3, 0);

    // Lower pressed while the round sits in HOLD.
    h0 = cnt_h; l0 = cnt_l;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) btn_higher_raw = 1'b1;
      if (c == 10) btn_higher_raw = 1'b0;
      if (c == 14) btn_lower_raw = 1'b1;
      if (c == 24) btn_lower_raw = 1'b0;
    end
    chk("holdpress_pulses_h", cnt_h - h0, 1);
    chk("holdpress_pulses_l", cnt_l - l0, 0);
    chk_counts("holdpress", 2, 3, 0);

    // Reset one cycle after the pulse; the later win code must not count.
    resp_code = 4'd10;
    found = 1'b0;
    btn_higher_raw = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (game_btn_higher) found = 1'b1;
    end
    chk("rstwait_pulse_seen", int'(found), 1);
    btn_higher_raw = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rstwait_pulse_h", int'(game_btn_higher), 0);
    chk("rstwait_pulse_l", int'(game_btn_lower), 0);
    chk_counts("rstwait", 0, 3, 0);
    chk("rstwait_disp", int'(disp_digit), 0);
    reset = 1'b0;
    h0 = cnt_h; l0 = cnt_l;
    repeat (40) @(negedge clk);
    chk("rstwait_after_pulses", (cnt_h - h0) + (cnt_l - l0), 0);
    chk_counts("rstwait_after", 0, 3, 0);

    // Table of whole rounds.
    for (int v = 0; v < 19; v++) begin
      resp_code = tbl[v].code;
      h0 = cnt_h; l0 = cnt_l; saw = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (c == 0) begin
          if (tbl[v].hi) btn_higher_raw = 1'b1;
          else btn_lower_raw = 1'b1;
        end
        if (c == 10) begin btn_higher_raw = 1'b0; btn_lower_raw = 1'b0; end
        if (tbl[v].code >= 4'd10 && disp_digit == tbl[v].code) saw = 1'b1;
      end
      chosen = tbl[v].hi ? (cnt_h - h0) : (cnt_l - l0);
      other  = tbl[v].hi ? (cnt_l - l0) : (cnt_h - h0);
      exp_disp = (tbl[v].exp_over != 0) ? tbl[v].exp_score : int'(BASE_VALUE);
      chk($sformatf("v%0d_pulse_sel", v), chosen, tbl[v].exp_p);
      chk($sformatf("v%0d_pulse_other", v), other, 0);
      chk_counts($sformatf("v%0d", v), tbl[v].exp_score, tbl[v].exp_lives, tbl[v].exp_over);
      chk($sformatf("v%0d_disp", v), int'(disp_digit), exp_disp);
      if (tbl[v].exp_p == 1 && tbl[v].code >= 4'd10)
        chk($sformatf("v%0d_disp_code", v), int'(saw), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
